mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the RISC-V core's instruction-fetch port and its load/store (MA-stage) data port.
- Maps both address spaces into one unified word-addressed memory, arbitrates per cycle, and routes the one-cycle-latency read data back to the requester that issued the read.
- Sits between the core's instruction/data memory interfaces and the shared memory macro.

Parameters:
P_DATA_WIDTH, 32, data word width
P_IMEM_ADDR_WIDTH, 9, instruction word-address width
P_DMEM_ADDR_WIDTH, 8, data word-address width
P_MEM_ADDR_WIDTH, 10, unified memory word-address width; must satisfy 2**P_MEM_ADDR_WIDTH >= P_DMEM_BASE + 2**P_DMEM_ADDR_WIDTH
P_DMEM_BASE, 512, unified word address of data word 0
P_STARVE_LIMIT, 4, consecutive stalled fetch cycles after which fetch gets priority

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
if_req  input  1  fetch read request; held until if_gnt
if_addr  input  P_IMEM_ADDR_WIDTH  fetch word address
if_gnt  output  1  fetch accepted this cycle (combinational)
if_rvalid  output  1  fetch read data valid
if_rdata  output  P_DATA_WIDTH  fetch read data
d_req  input  1  data request; held until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  P_DMEM_ADDR_WIDTH  data word address
d_wdata  input  P_DATA_WIDTH  write data
d_gnt  output  1  data request accepted this cycle (combinational)
d_rvalid  output  1  load data valid
d_rdata  output  P_DATA_WIDTH  load data
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  P_MEM_ADDR_WIDTH  unified word address
mem_wdata  output  P_DATA_WIDTH  memory write data
mem_rdata  input  P_DATA_WIDTH  memory read data, valid the cycle after a read strobe

Behaviour:
- Reset: starve_cnt=0, rsp_owner=NONE. if_rvalid=0, d_rvalid=0. if_rdata=0, d_rdata=0. Combinational outputs settle with req=0: gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Address map: fetch mem_addr = zero-extend(if_addr). Data mem_addr = P_DMEM_BASE + zero-extend(d_addr), truncated to P_MEM_ADDR_WIDTH.
- Arbitration is combinational each cycle, at most one grant per cycle:
  - Only one requester active: that one is granted.
  - Both active, starve_cnt < P_STARVE_LIMIT: data is granted.
  - Both active, starve_cnt >= P_STARVE_LIMIT: fetch is granted.
- On a grant: mem_en=1, mem_addr/mem_we/mem_wdata come from the winner. Fetch always drives mem_we=0; mem_wdata=0 when fetch is granted.
- starve_cnt:
  - Increments, saturating at P_STARVE_LIMIT, when if_req=1 and if_gnt=0.
  - Clears to 0 on if_gnt or when if_req=0.
- rsp_owner register (states NONE, IF, D), updated every cycle:
  - Fetch grant -> IF.
  - Data read grant (d_we=0) -> D.
  - Data write grant or no grant -> NONE.
- Read latency is exactly 1 cycle. In the cycle after a read grant, the owner's rvalid=1 and its rdata=mem_rdata. The non-owner's rvalid=0 and rdata=0. Both rdata outputs are 0 whenever their rvalid=0.
- Writes return no rvalid; d_gnt is the completion handshake.
- Back-to-back grants every cycle are allowed; throughput is 1 access per cycle.
- Requester protocol: addr/we/wdata stay stable while req=1 and gnt=0. Dropping req before gnt is allowed and simply withdraws the request.
- Reset mid-operation: an in-flight read's rvalid is suppressed and rsp_owner returns to NONE. No response is produced after reset deassertion.

Test Plan:
- Fetch only: if_req=1, if_addr=0x005, mem[5]=0xDEADBEEF -> same cycle if_gnt=1, mem_addr=0x005, mem_we=0. Next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Data write then read: d_we=1, d_addr=0x03, d_wdata=0x12345678 -> mem_addr=0x203, mem_we=1, d_gnt=1, no rvalid. Then d_we=0, d_addr=0x03 -> d_rvalid=1, d_rdata=0x12345678 one cycle later.
- Contention: if_req and d_req both held 1 with a new data read each cycle -> d_gnt for 4 cycles, if_gnt on cycle 5, starve_cnt then 0. The pattern repeats, and each rvalid goes only to its issuer.
- Alternating grants: fetch granted cycle N, data read granted cycle N+1 -> if_rvalid at N+1 and d_rvalid at N+2, each with the correct word. The two rvalids are never both high.
- Reset mid-read: fetch granted, reset asserted before the next clock edge -> if_rvalid=0 immediately and stays 0 after release. starve_cnt=0 and rsp_owner=NONE.
- Withdrawn request: if_req high for 2 stalled cycles then dropped -> starve_cnt returns to 0, and no fetch grant or response occurs.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the shared
// single-port SRAM. The arbiter connects through the slave modport. The core
// and memory side connects through the master modport.
interface mem_port_arbiter_if #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_IMEM_ADDR_WIDTH = 9,
    parameter int P_DMEM_ADDR_WIDTH = 8,
    parameter int P_MEM_ADDR_WIDTH  = 10
);
    logic                         if_req;
    logic [P_IMEM_ADDR_WIDTH-1:0] if_addr;
    logic                         if_gnt;
    logic                         if_rvalid;
    logic [P_DATA_WIDTH-1:0]      if_rdata;

    logic                         d_req;
    logic                         d_we;
    logic [P_DMEM_ADDR_WIDTH-1:0] d_addr;
    logic [P_DATA_WIDTH-1:0]      d_wdata;
    logic                         d_gnt;
    logic                         d_rvalid;
    logic [P_DATA_WIDTH-1:0]      d_rdata;

    logic                         mem_en;
    logic                         mem_we;
    logic [P_MEM_ADDR_WIDTH-1:0]  mem_addr;
    logic [P_DATA_WIDTH-1:0]      mem_wdata;
    logic [P_DATA_WIDTH-1:0]      mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and the
// load/store port. Data has priority. A fetch that has stalled for
// P_STARVE_LIMIT cycles wins the next contended cycle. Read data comes back
// one cycle after the grant and is steered to whichever port issued the read.
module mem_port_arbiter #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_IMEM_ADDR_WIDTH = 9,
    parameter int P_DMEM_ADDR_WIDTH = 8,
    parameter int P_MEM_ADDR_WIDTH  = 10,
    parameter int P_DMEM_BASE       = 512,
    parameter int P_STARVE_LIMIT    = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int C_CNT_W = $clog2(P_STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0]          C_LIMIT     = C_CNT_W'(P_STARVE_LIMIT);
    localparam logic [P_MEM_ADDR_WIDTH-1:0] C_DMEM_BASE = P_MEM_ADDR_WIDTH'(P_DMEM_BASE);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    logic [C_CNT_W-1:0] starve_cnt;
    logic [1:0]         rsp_owner;
    logic               fetch_win;
    logic               data_win;

    // Per-cycle arbitration: data wins contention unless fetch has starved long enough
    always_comb begin
        fetch_win = bus.if_req && (!bus.d_req || (starve_cnt >= C_LIMIT));
        data_win  = bus.d_req && !fetch_win;
    end

    // Drive grants and the memory strobe from the winner; everything idles at zero
    always_comb begin
        bus.if_gnt    = fetch_win;
        bus.d_gnt     = data_win;
        bus.mem_en    = fetch_win || data_win;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (fetch_win) begin
            bus.mem_addr = P_MEM_ADDR_WIDTH'(bus.if_addr);
        end else if (data_win) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = C_DMEM_BASE + P_MEM_ADDR_WIDTH'(bus.d_addr);
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Count consecutive stalled fetch cycles, saturating at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!bus.if_req || fetch_win) begin
            starve_cnt <= '0;
        end else if (starve_cnt < C_LIMIT) begin
            starve_cnt <= starve_cnt + C_CNT_W'(1);
        end
    end

    // Remember who issued the read being returned next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_owner <= OWN_NONE;
        end else if (fetch_win) begin
            rsp_owner <= OWN_IF;
        end else if (data_win && !bus.d_we) begin
            rsp_owner <= OWN_D;
        end else begin
            rsp_owner <= OWN_NONE;
        end
    end

    // Steer the SRAM read data to the owning port; the non-owner sees zeros
    always_comb begin
        bus.if_rvalid = (rsp_owner == OWN_IF);
        bus.d_rvalid  = (rsp_owner == OWN_D);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The bench holds an SRAM model. Stimulus
// checks grants and memory strobes in the same cycle and queues the expected
// read responses. A monitor matches each returned rvalid against those queues,
// including the cycle in which the response should appear.
module tb_mem_port_arbiter;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    rsp_t ifq[$];
    rsp_t dq[$];
    logic [7:0]  d_next;
    logic [31:0] mem [0:1023];

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10-unit period
    always #5 clk = ~clk;

    // Cycle counter used to timestamp expected responses
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int i);
        pat = (i == 5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
    endfunction

    // Single-port SRAM model with one-cycle read latency, reloaded on reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearInputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic applyStimulus(input logic ifr, input logic [8:0] ifa,
                                 input logic dr, input logic dwe, input logic [7:0] da,
                                 input logic [31:0] dwd,
                                 input logic exp_ig, input logic exp_dg,
                                 input logic [9:0] exp_addr, input logic [31:0] exp_rdata,
                                 input logic push);
        rsp_t r;
        @(posedge clk);
        #1;
        bus.if_req  = ifr;
        bus.if_addr = ifa;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        @(negedge clk);
        checkOutput("if_gnt", bus.if_gnt, exp_ig);
        checkOutput("d_gnt", bus.d_gnt, exp_dg);
        checkOutput("mem_en", bus.mem_en, exp_ig | exp_dg);
        checkOutput("mem_we", bus.mem_we, exp_dg & dwe);
        checkOutput("mem_addr", bus.mem_addr, exp_addr);
        checkOutput("mem_wdata", bus.mem_wdata, exp_dg ? dwd : 32'h0);
        if (push) begin
            r.data = exp_rdata;
            r.cyc  = cyc + 1;
            if (exp_ig)      ifq.push_back(r);
            else if (exp_dg) dq.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 9'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
    endtask

    // Both ports request every cycle: four data reads, then the starved fetch
    task automatic runRound(input logic [8:0] ia);
        for (int s = 0; s < 5; s++) begin
            if (s < 4) begin
                applyStimulus(1'b1, ia, 1'b1, 1'b0, d_next, 32'h0, 1'b0, 1'b1,
                              10'(10'h200 + {2'b00, d_next}), pat(512 + int'(d_next)), 1'b1);
                d_next = d_next + 8'd1;
            end else begin
                applyStimulus(1'b1, ia, 1'b1, 1'b0, d_next, 32'h0, 1'b1, 1'b0,
                              {1'b0, ia}, pat(int'(ia)), 1'b1);
            end
        end
    endtask

    // Monitor: pop and compare whenever a port presents read data
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            if (bus.if_rvalid || bus.d_rvalid)
                checkOutput("rvalid_exclusive", {31'h0, bus.if_rvalid & bus.d_rvalid}, 32'h0);
            if (bus.if_rvalid) begin
                if (ifq.size() == 0) begin
                    checkOutput("if_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = ifq.pop_front();
                    checkOutput("if_rdata", bus.if_rdata, e.data);
                    checkOutput("if_rsp_cycle", cyc, e.cyc);
                end
            end else begin
                checkOutput("if_rdata_idle", bus.if_rdata, 32'h0);
                if (ifq.size() > 0 && ifq[0].cyc <= cyc) begin
                    e = ifq.pop_front();
                    checkOutput("if_missing_rvalid", 32'h0, 32'h1);
                end
            end
            if (bus.d_rvalid) begin
                if (dq.size() == 0) begin
                    checkOutput("d_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    e = dq.pop_front();
                    checkOutput("d_rdata", bus.d_rdata, e.data);
                    checkOutput("d_rsp_cycle", cyc, e.cyc);
                end
            end else begin
                checkOutput("d_rdata_idle", bus.d_rdata, 32'h0);
                if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                    e = dq.pop_front();
                    checkOutput("d_missing_rvalid", 32'h0, 32'h1);
                end
            end
        end
    end

    // Directed sequence
    initial begin
        clearInputs();
        repeat (2) @(negedge clk);
        checkOutput("rst_if_rvalid", bus.if_rvalid, 0);
        checkOutput("rst_d_rvalid", bus.d_rvalid, 0);
        checkOutput("rst_if_rdata", bus.if_rdata, 0);
        checkOutput("rst_d_rdata", bus.d_rdata, 0);
        checkOutput("rst_if_gnt", bus.if_gnt, 0);
        checkOutput("rst_d_gnt", bus.d_gnt, 0);
        checkOutput("rst_mem_en", bus.mem_en, 0);
        checkOutput("rst_mem_we", bus.mem_we, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b0;

        // Fetch only
        applyStimulus(1'b1, 9'h005, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 10'h005, 32'hDEADBEEF, 1'b1);
        // Data write, then read back
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b1, 8'h03, 32'h12345678, 1'b0, 1'b1, 10'h203, 32'h0, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b0, 8'h03, 32'h0, 1'b0, 1'b1, 10'h203, 32'h12345678, 1'b1);
        // Alternating fetch and data reads
        applyStimulus(1'b1, 9'h020, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 10'h020, 32'hA500_0020, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b1, 1'b0, 8'h03, 32'h0, 1'b0, 1'b1, 10'h203, 32'h12345678, 1'b1);
        idle(2);

        // Contention, two full rounds
        d_next = 8'h40;
        runRound(9'h010);
        runRound(9'h011);
        idle(2);

        // Withdrawn fetch after two stalled cycles
        applyStimulus(1'b1, 9'h030, 1'b1, 1'b1, 8'h70, 32'h0BADF00D, 1'b0, 1'b1, 10'h270, 32'h0, 1'b0);
        applyStimulus(1'b1, 9'h030, 1'b1, 1'b1, 8'h71, 32'h0BADF00E, 1'b0, 1'b1, 10'h271, 32'h0, 1'b0);
        idle(1);
        runRound(9'h031);
        idle(2);

        // Reset while a fetch read is in flight
        applyStimulus(1'b1, 9'h005, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 10'h005, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        clearInputs();
        checkOutput("pre_rst_if_rvalid", bus.if_rvalid, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_rst_if_rvalid", bus.if_rvalid, 0);
        checkOutput("mid_rst_if_rdata", bus.if_rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(3);
        checkOutput("post_rst_if_rvalid", bus.if_rvalid, 0);

        // Reset with a stalled fetch and a data read in flight
        applyStimulus(1'b1, 9'h040, 1'b1, 1'b1, 8'h10, 32'h11111111, 1'b0, 1'b1, 10'h210, 32'h0, 1'b0);
        applyStimulus(1'b1, 9'h040, 1'b1, 1'b1, 8'h11, 32'h22222222, 1'b0, 1'b1, 10'h211, 32'h0, 1'b0);
        applyStimulus(1'b1, 9'h040, 1'b1, 1'b0, 8'h12, 32'h0, 1'b0, 1'b1, 10'h212, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        clearInputs();
        checkOutput("pre_rst_d_rvalid", bus.d_rvalid, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_rst_d_rvalid", bus.d_rvalid, 0);
        checkOutput("mid_rst_d_rdata", bus.d_rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(1);
        d_next = 8'h60;
        runRound(9'h050);
        idle(3);

        checkOutput("if_queue_drained", ifq.size(), 0);
        checkOutput("d_queue_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
